// File: rtl/keypad_pkg.sv
// Shared keypad definitions: scanner state encoding, key-class (sign) codes
// and special key codes, also imported by the operand-entry FSM.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    localparam logic [2:0] SIGN_NONE = 3'b000;
    localparam logic [2:0] SIGN_MUL  = 3'b001;
    localparam logic [2:0] SIGN_B    = 3'b010;
    localparam logic [2:0] SIGN_C    = 3'b011;
    localparam logic [2:0] SIGN_D    = 3'b100;
    localparam logic [2:0] SIGN_CLR  = 3'b101;
    localparam logic [2:0] SIGN_EQ   = 3'b111;

    localparam logic [3:0] KEY_STAR  = 4'hE;
    localparam logic [3:0] KEY_HASH  = 4'hF;

    // Rows are active-low; the lowest-index low row wins.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic multi_low(input logic [3:0] rows);
        return ($countones(~rows) > 1);
    endfunction

endpackage

// File: rtl/keypad_key_decode.sv
// Combinational key map: (row, column) of the 4x4 pad to {key_value, is_sign_key}.
module keypad_key_decode
    import keypad_pkg::*;
(
    input  logic [1:0] row_idx,
    input  logic [1:0] col_idx,
    output logic [3:0] key_value,
    output logic [2:0] is_sign_key
);

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        key_value   = 4'h0;
        is_sign_key = SIGN_NONE;
        if (col_idx == 2'd3) begin
            key_value = 4'hA + 4'(row_idx);
            case (row_idx)
                2'd0:    is_sign_key = SIGN_MUL;
                2'd1:    is_sign_key = SIGN_B;
                2'd2:    is_sign_key = SIGN_C;
                default: is_sign_key = SIGN_D;
            endcase
        end else if (row_idx == 2'd3) begin
            case (col_idx)
                2'd0: begin
                    key_value   = KEY_STAR;
                    is_sign_key = SIGN_CLR;
                end
                2'd1:    key_value = 4'h0;
                default: begin
                    key_value   = KEY_HASH;
                    is_sign_key = SIGN_EQ;
                end
            endcase
        end else begin
            // Digit block 1..9 laid out row-major.
            key_value = 4'(row_idx) * 4'd3 + 4'(col_idx) + 4'd1;
        end
    end

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad scanner with row synchronizer, press/release debounce and key encoding.
// Build option: define KEYPAD_MULTIKEY_REJECT_EN to treat multi-row samples as no key.
module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_pressed,
    output logic       key_strobe,
    output logic [3:0] key_value,
    output logic [2:0] is_sign_key
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DBC_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SCAN_W-1:0] DWELL_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DBC_W-1:0]  DBC_DONE   = DBC_W'(DEBOUNCE_CYCLES);

    scan_state_t       state_q, state_d;
    logic [1:0]        col_q, col_d;
    logic [1:0]        row_q, row_d;
    logic [SCAN_W-1:0] dwell_q, dwell_d;
    logic [DBC_W-1:0]  dbc_q, dbc_d;
    logic              key_pressed_q, key_pressed_d;
    logic              key_strobe_q, key_strobe_d;
    logic [3:0]        key_value_q, key_value_d;
    logic [2:0]        is_sign_key_q, is_sign_key_d;
    logic [3:0]        row_meta_q, rows_s_q;

    logic [3:0] dec_value;
    logic [2:0] dec_sign;
    logic       key_seen;
    logic       row_held;

    keypad_key_decode u_decode (
        .row_idx     (row_q),
        .col_idx     (col_q),
        .key_value   (dec_value),
        .is_sign_key (dec_sign)
    );

`ifdef KEYPAD_MULTIKEY_REJECT_EN
    assign key_seen = (rows_s_q != 4'hF) && !multi_low(rows_s_q);
    assign row_held = !rows_s_q[row_q] && !multi_low(rows_s_q);
`else
    assign key_seen = (rows_s_q != 4'hF);
    assign row_held = !rows_s_q[row_q];
`endif

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        dwell_d       = dwell_q;
        dbc_d         = dbc_q;
        key_pressed_d = key_pressed_q;
        key_strobe_d  = 1'b0;
        key_value_d   = key_value_q;
        is_sign_key_d = is_sign_key_q;
        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (key_seen) begin
                        row_d   = lowest_low_row(rows_s_q);
                        dbc_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + SCAN_W'(1);
                end
            end
            DEBOUNCE: begin
                if (row_held) begin
                    if (dbc_q == DBC_DONE) begin
                        key_value_d   = dec_value;
                        is_sign_key_d = dec_sign;
                        key_pressed_d = 1'b1;
                        key_strobe_d  = 1'b1;
                        state_d       = PRESSED;
                    end else begin
                        dbc_d = dbc_q + DBC_W'(1);
                    end
                end else begin
                    dwell_d = '0;
                    state_d = SCAN;
                end
            end
            PRESSED: begin
                if (rows_s_q[row_q]) begin
                    dbc_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // Any low row, including a second key, restarts the release window.
                if (&rows_s_q) begin
                    if (dbc_q == DBC_DONE) begin
                        key_pressed_d = 1'b0;
                        col_d         = col_q + 2'd1;
                        dwell_d       = '0;
                        state_d       = SCAN;
                    end else begin
                        dbc_d = dbc_q + DBC_W'(1);
                    end
                end else begin
                    dbc_d = '0;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= SCAN;
            col_q         <= 2'd0;
            row_q         <= 2'd0;
            dwell_q       <= '0;
            dbc_q         <= '0;
            key_pressed_q <= 1'b0;
            key_strobe_q  <= 1'b0;
            key_value_q   <= 4'h0;
            is_sign_key_q <= SIGN_NONE;
            row_meta_q    <= 4'hF;
            rows_s_q      <= 4'hF;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            dwell_q       <= dwell_d;
            dbc_q         <= dbc_d;
            key_pressed_q <= key_pressed_d;
            key_strobe_q  <= key_strobe_d;
            key_value_q   <= key_value_d;
            is_sign_key_q <= is_sign_key_d;
            row_meta_q    <= row_in;
            rows_s_q      <= row_meta_q;
        end
    end

    assign col_out     = ~(4'b0001 << col_q);
    assign key_pressed = key_pressed_q;
    assign key_strobe  = key_strobe_q;
    assign key_value   = key_value_q;
    assign is_sign_key = is_sign_key_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder with SCAN_DIV=4, DEBOUNCE_CYCLES=8 and a
// behavioural keypad that pulls a row low when a held key's column is driven.
module tb_keypad_scan_encoder;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_pressed;
    logic       key_strobe;
    logic [3:0] key_value;
    logic [2:0] is_sign_key;

    logic [15:0] key_mask = '0;   // bit r*4+c set = key at row r, column c held
    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int strobes = 0;

    keypad_scan_encoder #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row_in      (row_in),
        .col_out     (col_out),
        .key_pressed (key_pressed),
        .key_strobe  (key_strobe),
        .key_value   (key_value),
        .is_sign_key (is_sign_key)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_mask[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (key_strobe) strobes++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        key_mask = '0;
        #2 rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"},   32'(col_out),     32'hE);
        check({tag, "_prs"},   32'(key_pressed), 0);
        check({tag, "_stb"},   32'(key_strobe),  0);
        check({tag, "_val"},   32'(key_value),   0);
        check({tag, "_sign"},  32'(is_sign_key), 0);
    endtask

    initial begin
        logic [3:0] exp_col;

        // Reset state
        #1;
        check_reset_outputs("rst0");
        tick();
        tick();
        rst = 1'b1;
        cyc = 0;

        // 1: idle scan rotation, one column per SCAN_DIV cycles
        check("t1_col0", 32'(col_out), 32'hE);
        for (int i = 0; i < 64; i++) begin
            tick();
            exp_col = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
            check("t1_col", 32'(col_out), 32'(exp_col));
            if (cyc % 4 == 0) check("t1_prs", 32'(key_pressed), 0);
        end
        check("t1_stb_cnt", 32'(strobes), 0);

        // 2: key 6 (r1,c2): column 2 sampled at edge 12, press accepted at edge 21
        do_reset();
        strobes  = 0;
        key_mask = 16'(1 << 6);
        goto(20);
        check("t2_early", 32'(key_pressed), 0);
        goto(21);
        check("t2_prs",  32'(key_pressed), 1);
        check("t2_stb",  32'(key_strobe),  1);
        check("t2_val",  32'(key_value),   6);
        check("t2_sign", 32'(is_sign_key), 0);
        check("t2_col",  32'(col_out),     32'hB);
        goto(22);
        check("t2_stb_off", 32'(key_strobe),  0);
        check("t2_hold",    32'(key_pressed), 1);
        goto(30);
        key_mask = '0;
        goto(41);
        check("t2_rel_early", 32'(key_pressed), 1);
        goto(42);
        check("t2_rel",      32'(key_pressed), 0);
        check("t2_rel_col",  32'(col_out),     32'h7);
        check("t2_val_held", 32'(key_value),   6);
        check("t2_stb_cnt",  32'(strobes),     1);

        // 3: A (r0,c3) then # (r3,c2)
        strobes  = 0;
        key_mask = 16'(1 << 3);
        goto(54);
        check("t3a_early", 32'(key_pressed), 0);
        goto(55);
        check("t3a_prs",  32'(key_pressed), 1);
        check("t3a_val",  32'(key_value),   32'hA);
        check("t3a_sign", 32'(is_sign_key), 1);
        goto(56);
        key_mask = '0;
        goto(67);
        check("t3a_hold", 32'(key_pressed), 1);
        goto(68);
        check("t3a_rel",  32'(key_pressed), 0);
        check("t3a_col",  32'(col_out),     32'hE);
        key_mask = 16'(1 << 14);
        goto(88);
        check("t3h_early", 32'(key_pressed), 0);
        goto(89);
        check("t3h_prs",  32'(key_pressed), 1);
        check("t3h_val",  32'(key_value),   32'hF);
        check("t3h_sign", 32'(is_sign_key), 7);
        goto(90);
        key_mask = '0;
        goto(102);
        check("t3h_rel",     32'(key_pressed), 0);
        check("t3h_col",     32'(col_out),     32'h7);
        check("t3_stb_cnt",  32'(strobes),     2);

        // 4: row 2 on column 0 bouncing every 3 cycles
        strobes = 0;
        goto(106);
        for (int k = 0; k < 10; k++) begin
            key_mask = (k % 2 == 0) ? 16'(1 << 8) : 16'h0;
            for (int j = 0; j < 3; j++) begin
                tick();
                check("t4_prs", 32'(key_pressed), 0);
            end
        end
        key_mask = '0;
        goto(150);
        check("t4_prs_end", 32'(key_pressed), 0);
        check("t4_stb_cnt", 32'(strobes),     0);

        // 5: asynchronous reset while a key is held in PRESSED
        do_reset();
        strobes  = 0;
        key_mask = 16'(1 << 5);
        goto(17);
        check("t5_prs", 32'(key_pressed), 1);
        check("t5_val", 32'(key_value),   5);
        #3 rst = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        tick();
        tick();
        rst = 1'b1;
        cyc = 0;
        check("t5_col0", 32'(col_out), 32'hE);
        goto(3);
        check("t5_col3", 32'(col_out), 32'hE);
        goto(4);
        check("t5_col4", 32'(col_out), 32'hD);
        goto(17);
        check("t5_reprs", 32'(key_pressed), 1);

        // 6: rows 0 and 2 low together on column 1
        do_reset();
        strobes  = 0;
        key_mask = 16'((1 << 1) | (1 << 9));
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        goto(40);
        check("t6_prs",     32'(key_pressed), 0);
        check("t6_stb_cnt", 32'(strobes),     0);
`else
        goto(17);
        check("t6_prs",  32'(key_pressed), 1);
        check("t6_val",  32'(key_value),   2);
        check("t6_sign", 32'(is_sign_key), 0);
        goto(40);
        check("t6_stb_cnt", 32'(strobes), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
